risc_v_32_lsu: RTL and testbench
================================

# risc_v_32_lsu

Load/store unit for the RV32IM MEM stage; supersedes the combinational load-data aligner. It accepts one load or store per transaction from EX and drives a word-addressed data bus with a request/acknowledge handshake. It aligns store data and byte enables, and extracts and sign/zero-extends load data. It splits misaligned accesses into two bus beats and reports misalignment or bus-timeout errors back to the pipeline.

## Interface
- `ALLOW_MISALIGNED`, default 1: 1 = split word-crossing accesses into two beats; 0 = flag them as errors with no bus access.
- `TIMEOUT`, default 255: maximum number of cycles `bus_req` waits for `bus_ack` per beat before an error is raised; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: EX presents an access.
- `req_ready` out 1: unit can accept an access.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `bus_req` out 1: bus access request.
- `bus_we` out 1: write enable.
- `bus_addr` out 32: word-aligned address, bits [1:0] always 0.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-aligned write data.
- `bus_ack` in 1: beat completes; `bus_rdata` is valid this cycle.
- `bus_rdata` in 32: read word.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: misaligned-when-disallowed, illegal funct3, or timeout.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- `req_ready` = (state == IDLE) && !rst.
- Accept the request on `req_valid && req_ready`; latch store, funct3, addr and wdata.
- Size is 1 byte for funct3[1:0]=00, 2 for 01, 4 for 10.
- The request is illegal when funct3 is 011, 110 or 111, or when a store uses funct3 100 or 101.
- Let off = addr[1:0]. The access crosses a word when off + size > 4.
- On accept, go IDLE → RESP with `resp_err`=1 and no bus activity if the request is illegal, or if it crosses a word and ALLOW_MISALIGNED=0.
- Otherwise go IDLE → BEAT0.
- Byte mask: the 8-bit value ((1<<size)−1) << off.
  - BEAT0 uses mask[3:0] and addr & ~3.
  - BEAT1 uses mask[7:4] and (addr & ~3) + 4.
- Store data: the 64-bit value wdata << (8·off). BEAT0 drives its low word and BEAT1 its high word.
- BEAT0 on `bus_ack`:
  - capture `bus_rdata` into r0;
  - go to BEAT1 if the access crosses a word, else to RESP.
- BEAT1 on `bus_ack`: capture `bus_rdata` into r1 and go to RESP.
- Load result: ({r1,r0} >> 8·off)[size·8−1:0], sign-extended for funct3[2]=0 and zero-extended for funct3[2]=1.
- RESP: `resp_valid`=1 for exactly one cycle, then return to IDLE. There is no response backpressure.
- Timeout: a per-beat counter clears on entry to each beat. If it reaches TIMEOUT without an ack, drop `bus_req`, go to RESP with `resp_err`=1, and discard any partial store. The first beat of a split store may already be committed; this is a documented precise-exception limitation.
- Reset mid-transaction: the unit returns to IDLE on the next edge, `bus_req` falls immediately, and no response is issued.

## Timing
- Reset values: `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `resp_valid`, `resp_data` and `resp_err` are all 0; state is IDLE.
- All bus and response outputs are registered.
- Bus rule: `bus_req` stays high, and addr/be/we/wdata stay stable, until the cycle `bus_ack` is sampled high.
- `bus_ack` is ignored while `bus_req` is low.
- Latency, aligned access: accept at cycle 0 puts `bus_req` high at cycle 1. An ack at cycle 1 gives `resp_valid` at cycle 2.
- Latency, split access with zero-wait acks: `resp_valid` at cycle 3.
- Each wait cycle adds one cycle of latency.
- Illegal request: `resp_valid` one cycle after accept.
- Throughput: one transaction per (latency + 1) cycles. `req_ready` is low from BEAT0 through RESP.

## Structure
- Shared package `rv32_pkg` holds:
  - funct3 load/store constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the state encoding;
  - the `lsu_size_t` width type.
- One natural sub-module: `risc_v_32_load_extract`, a combinational unit mapping ({r1,r0}, off, funct3) → 32-bit result. It generalises the old aligner to a 64-bit window.
- The FSM, timeout counter and store lane alignment stay in the top module.

## Test plan
- **lw, aligned:** addr 0x100, zero-wait ack with rdata 0xDEADBEEF → exactly one beat at 0x100 with be 1111; resp_data 0xDEADBEEF at cycle 2; resp_err 0.
- **lb / lhu, offsets:** addr 0x103 with rdata 0x80xxxxxx → 0xFFFFFF80. lhu at addr 0x102 with rdata 0x1234xxxx → 0x00001234.
- **Misaligned lw:** addr 0x0FE, beats return 0xAABBxxxx then 0xxxxxCCDD → beats at 0x0FC (be 1100) and 0x100 (be 0011); resp_data 0xCCDDAABB at cycle 3. With ALLOW_MISALIGNED=0: no `bus_req`; resp_err 1 at cycle 1.
- **Misaligned sh:** addr 0x103, wdata 0x0000BEEF → beat0 be 1000 with wdata[31:24]=0xEF; beat1 be 0001 with wdata[7:0]=0xBE.
- **Waits and timeout:** ack after 5 wait cycles → `bus_*` outputs stable throughout, then resp_valid. With TIMEOUT=4 and no ack → `bus_req` drops after 4 cycles; resp_err 1 and resp_data 0.
- **Reset and illegal request:** `rst` asserted during BEAT1 → `bus_req` 0 next cycle; no resp_valid; `req_ready` 1 the cycle after `rst` deasserts. funct3 011 → resp_err with no bus activity.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 load/store definitions: funct3 codes, LSU state encoding and
// access-size helpers used by the load/store unit and its load extractor.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } lsu_state_t;

  // Access size in bytes (1, 2 or 4); 0 marks the reserved size code.
  typedef logic [2:0] lsu_size_t;

  function automatic lsu_size_t lsu_size(input logic [1:0] size_code);
    case (size_code)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Reserved encodings, plus unsigned variants that only make sense for loads.
  function automatic logic lsu_illegal(input logic store, input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3[2] && funct3[1]) || (store && funct3[2]);
  endfunction

endpackage

// File: rtl/risc_v_32_load_extract.sv
// Combinational load-data extractor: selects the addressed bytes out of a
// two-word window and sign- or zero-extends them to 32 bits.
module risc_v_32_load_extract
  import rv32_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lo;

  assign lo = 32'(window >> {off, 3'b000});

  // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{24{lo[7]}}, lo[7:0]};
      F3_BU:   data = {24'b0, lo[7:0]};
      F3_H:    data = {{16{lo[15]}}, lo[15:0]};
      F3_HU:   data = {16'b0, lo[15:0]};
      F3_W:    data = lo;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/risc_v_32_lsu.sv
// RV32 MEM-stage load/store unit: one access per transaction over a word bus
// with req/ack, splitting word-crossing accesses into two beats.
module risc_v_32_lsu
  import rv32_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int TIMEOUT          = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] r0_q, r0_d;
  logic        load_en;

  logic        bus_req_d, bus_we_d;
  logic [31:0] bus_addr_d, bus_wdata_d;
  logic [3:0]  bus_be_d;
  logic        resp_valid_d, resp_err_d;
  logic [31:0] resp_data_d;

  // Lane computation works on the incoming request while idle and on the
  // latched request during the beats, so one copy serves both.
  logic        idle;
  logic        src_store;
  logic [2:0]  src_f3;
  logic [31:0] src_addr, src_wdata, base_addr;
  logic [1:0]  off;
  lsu_size_t   size;
  logic [7:0]  mask_base, mask8;
  logic [63:0] wdata64;
  logic        crosses, illegal;

  assign idle      = (state_q == ST_IDLE);
  assign req_ready = idle && !rst;
  assign src_store = idle ? req_store  : store_q;
  assign src_f3    = idle ? req_funct3 : f3_q;
  assign src_addr  = idle ? req_addr   : addr_q;
  assign src_wdata = idle ? req_wdata  : wdata_q;
  assign base_addr = {src_addr[31:2], 2'b00};
  assign off       = src_addr[1:0];
  assign size      = lsu_size(src_f3[1:0]);
  assign mask_base = (size == 3'd1) ? 8'h01 :
                     (size == 3'd2) ? 8'h03 :
                     (size == 3'd4) ? 8'h0F : 8'h00;
  assign mask8     = mask_base << off;
  assign wdata64   = {32'b0, src_wdata} << {off, 3'b000};
  assign crosses   = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign illegal   = lsu_illegal(src_store, src_f3);

  // Before the second beat lands only r0 is meaningful.
  logic [63:0] window;
  logic [31:0] load_data;

  assign window = (state_q == ST_BEAT1) ? {bus_rdata, r0_q} : {32'b0, bus_rdata};

  risc_v_32_load_extract u_extract (
    .window (window),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    r0_d         = r0_q;
    load_en      = 1'b0;
    bus_req_d    = bus_req;
    bus_we_d     = bus_we;
    bus_addr_d   = bus_addr;
    bus_be_d     = bus_be;
    bus_wdata_d  = bus_wdata;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          load_en = 1'b1;
          if (illegal || (crosses && !ALLOW_MISALIGNED)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ST_BEAT0;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = req_store;
            bus_addr_d  = base_addr;
            bus_be_d    = mask8[3:0];
            bus_wdata_d = wdata64[31:0];
          end
        end
      end

      ST_BEAT0, ST_BEAT1: begin
        if (bus_ack) begin
          if (state_q == ST_BEAT0 && crosses) begin
            state_d     = ST_BEAT1;
            cnt_d       = '0;
            r0_d        = bus_rdata;
            bus_addr_d  = base_addr + 32'd4;
            bus_be_d    = mask8[7:4];
            bus_wdata_d = wdata64[63:32];
          end else begin
            state_d      = ST_RESP;
            bus_req_d    = 1'b0;
            resp_valid_d = 1'b1;
            resp_data_d  = store_q ? 32'b0 : load_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_RESP;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_req    <= bus_req_d;
      bus_we     <= bus_we_d;
      bus_addr   <= bus_addr_d;
      bus_be     <= bus_be_d;
      bus_wdata  <= bus_wdata_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
    end
  end

  // NOTE: request and read-data holding registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (load_en) begin
      store_q <= req_store;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    r0_q <= r0_d;
  end

endmodule

// File: tb/tb_risc_v_32_lsu.sv
// Self-checking bench for risc_v_32_lsu: directed vector table, multi-cycle
// corner sequences, and random traffic against a byte-array memory model.
module tb_risc_v_32_lsu;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main unit: misaligned accesses allowed, long timeout.
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;

  // Strict unit: misaligned accesses rejected, short timeout, bus never acks.
  logic        s_req_valid, s_req_ready, s_req_store;
  logic [2:0]  s_req_funct3;
  logic [31:0] s_req_addr, s_req_wdata;
  logic        s_bus_req, s_bus_we;
  logic        s_bus_ack = 1'b0;
  logic [31:0] s_bus_addr, s_bus_wdata;
  logic [31:0] s_bus_rdata = 32'h0;
  logic [3:0]  s_bus_be;
  logic        s_resp_valid, s_resp_err;
  logic [31:0] s_resp_data;

  risc_v_32_lsu #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  risc_v_32_lsu #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT(4)) dut_strict (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_store(s_req_store),
    .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .bus_req(s_bus_req), .bus_we(s_bus_we), .bus_addr(s_bus_addr), .bus_be(s_bus_be),
    .bus_wdata(s_bus_wdata), .bus_ack(s_bus_ack), .bus_rdata(s_bus_rdata),
    .resp_valid(s_resp_valid), .resp_data(s_resp_data), .resp_err(s_resp_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  logic [31:0] bus_mem [128];
  logic [7:0]  ref_mem [512];
  beat_t       beats [$];
  int          fixed_wait = 0;
  bit          rand_wait  = 1'b0;
  int          ack_budget = -1;

  function automatic int pick_wait();
    return rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
  endfunction

  // Bus slave: word memory, programmable wait states, stability tracking.
  initial begin : responder
    beat_t cur, snap;
    int    waits_left;
    bit    in_beat, stable;
    bus_ack = 1'b0; bus_rdata = '0;
    in_beat = 1'b0; stable = 1'b1; waits_left = 0; snap = '0;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (bus_req && !rst) begin
        cur = {bus_we, bus_addr, bus_be, bus_wdata};
        if (!in_beat) begin
          in_beat = 1'b1; snap = cur; stable = 1'b1; waits_left = pick_wait();
        end else if (cur != snap) begin
          stable = 1'b0;
        end
        if (ack_budget != 0) begin
          if (waits_left == 0) begin
            bus_ack   = 1'b1;
            bus_rdata = bus_mem[cur.addr[8:2]];
            if (cur.we)
              for (int i = 0; i < 4; i++)
                if (cur.be[i]) bus_mem[cur.addr[8:2]][8*i +: 8] = cur.wdata[8*i +: 8];
            beats.push_back(cur);
            check("bus_stable", {31'b0, stable}, 32'd1);
            in_beat = 1'b0;
            if (ack_budget > 0) ack_budget--;
          end else begin
            waits_left--;
          end
        end
      end else begin
        in_beat = 1'b0;
      end
    end
  end

  // One transaction on the main unit; called and returns at posedge+1.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] data,
                        output logic err, output int lat);
    int n;
    beats.delete();
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) check("req_ready_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("req_ready_busy", {31'b0, req_ready}, 32'd0);
    lat = 1;
    while (!resp_valid && lat < 400) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) check("resp_seen", 32'd0, 32'd1);
    data = resp_data;
    err  = resp_err;
    @(posedge clk); #1;
    check("resp_pulse", {31'b0, resp_valid}, 32'd0);
  endtask

  // Byte-level reference model.
  function automatic bit ref_legal(input logic st, input logic [2:0] f3);
    return st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  endfunction

  function automatic int ref_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int          nb;
    nb = ref_bytes(f3);
    v  = 0;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[(a + i) % 512]) << (8 * i));
    if (!f3[2]) begin
      if (nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (nb == 2 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  typedef struct {
    string       name;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, m0, m1, exp_data;
    logic        exp_err;
    int          exp_lat, exp_beats;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1;
  } vec_t;

  vec_t vecs [12];

  initial begin : main
    logic [31:0] data, exp, w;
    logic        err, st;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    int          lat, n, hi;

    vecs[0]  = '{"lw_aligned",  1'b0, F3_W,   32'h100, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 4'b1111, 4'b0000, 32'h0,        32'h0};
    vecs[1]  = '{"lb_off3",     1'b0, F3_B,   32'h103, 32'h0,        32'h80123456, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 4'b1000, 4'b0000, 32'h0,        32'h0};
    vecs[2]  = '{"lhu_off2",    1'b0, F3_HU,  32'h102, 32'h0,        32'h1234ABCD, 32'h0,        32'h00001234, 1'b0, 2, 1, 4'b1100, 4'b0000, 32'h0,        32'h0};
    vecs[3]  = '{"lw_split",    1'b0, F3_W,   32'h0FE, 32'h0,        32'hAABB1122, 32'h5566CCDD, 32'hCCDDAABB, 1'b0, 3, 2, 4'b1100, 4'b0011, 32'h0,        32'h0};
    vecs[4]  = '{"sh_split",    1'b1, F3_H,   32'h103, 32'h0000BEEF, 32'h0,        32'h0,        32'h0,        1'b0, 3, 2, 4'b1000, 4'b0001, 32'hEF000000, 32'h000000BE};
    vecs[5]  = '{"f3_011",      1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 4'b0000, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{"sb_off1",     1'b1, F3_B,   32'h101, 32'h123456A5, 32'h0,        32'h0,        32'h0,        1'b0, 2, 1, 4'b0010, 4'b0000, 32'h3456A500, 32'h0};
    vecs[7]  = '{"store_f3_100",1'b1, 3'b100, 32'h100, 32'h11111111, 32'h0,        32'h0,        32'h0,        1'b1, 1, 0, 4'b0000, 4'b0000, 32'h0,        32'h0};
    vecs[8]  = '{"lh_split",    1'b0, F3_H,   32'h0FF, 32'h0,        32'h80000000, 32'h000000FF, 32'hFFFFFF80, 1'b0, 3, 2, 4'b1000, 4'b0001, 32'h0,        32'h0};
    vecs[9]  = '{"lbu_off0",    1'b0, F3_BU,  32'h100, 32'h0,        32'hDEADBE85, 32'h0,        32'h00000085, 1'b0, 2, 1, 4'b0001, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{"sw_aligned",  1'b1, F3_W,   32'h104, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0,        1'b0, 2, 1, 4'b1111, 4'b0000, 32'hCAFEF00D, 32'h0};
    vecs[11] = '{"lh_off2",     1'b0, F3_H,   32'h102, 32'h0,        32'h80010000, 32'h0,        32'hFFFF8001, 1'b0, 2, 1, 4'b1100, 4'b0000, 32'h0,        32'h0};

    for (int i = 0; i < 128; i++) bus_mem[i] = '0;
    req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    s_req_valid = 0; s_req_store = 0; s_req_funct3 = 0; s_req_addr = 0; s_req_wdata = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.bus_req",    {31'b0, bus_req},    32'd0);
    check("rst.bus_we",     {31'b0, bus_we},     32'd0);
    check("rst.bus_addr",   bus_addr,            32'd0);
    check("rst.bus_be",     {28'b0, bus_be},     32'd0);
    check("rst.bus_wdata",  bus_wdata,           32'd0);
    check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst.resp_data",  resp_data,           32'd0);
    check("rst.resp_err",   {31'b0, resp_err},   32'd0);
    check("rst.req_ready",  {31'b0, req_ready},  32'd0);
    rst = 1'b0;
    #1;
    check("rst.req_ready_after", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed vector table, zero-wait bus
    foreach (vecs[k]) begin
      bus_mem[vecs[k].addr[8:2]]            = vecs[k].m0;
      bus_mem[(vecs[k].addr[8:2] + 7'd1)]   = vecs[k].m1;
      do_req(vecs[k].store, vecs[k].f3, vecs[k].addr, vecs[k].wdata, data, err, lat);
      check({vecs[k].name, ".data"},  data,             vecs[k].exp_data);
      check({vecs[k].name, ".err"},   {31'b0, err},     {31'b0, vecs[k].exp_err});
      check({vecs[k].name, ".lat"},   lat,              vecs[k].exp_lat);
      check({vecs[k].name, ".beats"}, beats.size(),     vecs[k].exp_beats);
      for (int b = 0; b < beats.size() && b < 2; b++) begin
        check($sformatf("%s.b%0d_addr", vecs[k].name, b), beats[b].addr,
              {vecs[k].addr[31:2], 2'b00} + 32'(4 * b));
        check($sformatf("%s.b%0d_be", vecs[k].name, b), {28'b0, beats[b].be},
              {28'b0, (b == 0) ? vecs[k].be0 : vecs[k].be1});
        check($sformatf("%s.b%0d_we", vecs[k].name, b), {31'b0, beats[b].we},
              {31'b0, vecs[k].store});
        if (vecs[k].store)
          check($sformatf("%s.b%0d_wdata", vecs[k].name, b), beats[b].wdata,
                (b == 0) ? vecs[k].wd0 : vecs[k].wd1);
      end
    end

    // Five wait states: outputs held steady, latency grows by five
    fixed_wait = 5;
    bus_mem[32'h100 >> 2] = 32'h0BADF00D;
    do_req(1'b0, F3_W, 32'h100, 32'h0, data, err, lat);
    check("wait5.data",  data, 32'h0BADF00D);
    check("wait5.lat",   lat, 32'd7);
    check("wait5.beats", beats.size(), 32'd1);
    fixed_wait = 0;

    // Strict unit: misaligned word is rejected without touching the bus
    s_req_valid = 1'b1; s_req_store = 1'b0; s_req_funct3 = F3_W; s_req_addr = 32'h0FE;
    check("strict.ready", {31'b0, s_req_ready}, 32'd1);
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    check("strict_mis.valid",   {31'b0, s_resp_valid}, 32'd1);
    check("strict_mis.err",     {31'b0, s_resp_err},   32'd1);
    check("strict_mis.data",    s_resp_data,           32'd0);
    check("strict_mis.bus_req", {31'b0, s_bus_req},    32'd0);
    @(posedge clk); #1;
    check("strict_mis.pulse",   {31'b0, s_resp_valid}, 32'd0);
    check("strict_mis.no_bus",  {31'b0, s_bus_req},    32'd0);

    // Strict unit: aligned load that never gets an ack times out after 4 cycles
    s_req_valid = 1'b1; s_req_funct3 = F3_W; s_req_addr = 32'h40;
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    n = 1; hi = 0;
    while (!s_resp_valid && n < 20) begin
      if (s_bus_req) hi++;
      @(posedge clk); #1;
      n++;
    end
    check("timeout.req_cycles", hi, 32'd4);
    check("timeout.lat",        n, 32'd5);
    check("timeout.err",        {31'b0, s_resp_err},  32'd1);
    check("timeout.data",       s_resp_data,          32'd0);
    check("timeout.bus_req",    {31'b0, s_bus_req},   32'd0);
    @(posedge clk); #1;

    // Reset during the second beat of a split load
    ack_budget = 1;
    beats.delete();
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_W; req_addr = 32'h0FE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!(bus_req && bus_addr == 32'h100) && n < 20) begin @(posedge clk); #1; n++; end
    check("rst_mid.reached_beat1", {31'b0, bus_req && bus_addr == 32'h100}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.bus_req",    {31'b0, bus_req},    32'd0);
    check("rst_mid.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mid.ready_rst",  {31'b0, req_ready},  32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid.ready_after", {31'b0, req_ready}, 32'd1);
    hi = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid || bus_req) hi++;
    end
    check("rst_mid.quiet", hi, 32'd0);
    ack_budget = -1;

    // Random traffic against the byte-array reference
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      bus_mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    rand_wait = 1'b1;
    for (int t = 0; t < 300; t++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(3, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      a  = 32'($urandom_range(0, 32'h1F7));
      wd = $urandom;
      exp = (!st && ref_legal(st, f3)) ? ref_load(a, f3) : 32'h0;
      do_req(st, f3, a, wd, data, err, lat);
      check($sformatf("rand%0d.data", t), data, exp);
      check($sformatf("rand%0d.err", t), {31'b0, err}, {31'b0, !ref_legal(st, f3)});
      if (st && ref_legal(st, f3))
        for (int b = 0; b < ref_bytes(f3); b++) ref_mem[(a + b) % 512] = wd[8*b +: 8];
    end
    rand_wait = 1'b0;

    for (int i = 0; i < 128; i++)
      check($sformatf("mem_word%0d", i), bus_mem[i],
            {ref_mem[4*i + 3], ref_mem[4*i + 2], ref_mem[4*i + 1], ref_mem[4*i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
